// File: rtl/mem_stage_sram_pkg.sv
// Shared constants for the SRAM-backed memory stage: FSM state encodings
// and default parameter values.
package mem_stage_sram_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_LO = 3'd1;
  localparam logic [2:0] ST_RD_HI = 3'd2;
  localparam logic [2:0] ST_WR_LO = 3'd3;
  localparam logic [2:0] ST_WR_HI = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    RD_LO = ST_RD_LO,
    RD_HI = ST_RD_HI,
    WR_LO = ST_WR_LO,
    WR_HI = ST_WR_HI,
    DONE  = ST_DONE
  } state_e;

  localparam int DEF_BASE_ADDR = 1024;
  localparam int DEF_SRAM_WAIT = 3;
  localparam int DEF_ADDR_W    = 18;

endpackage

// File: rtl/mem_stage_sram.sv
// Memory stage: turns a 32-bit LDR/STR into two 16-bit SRAM transactions
// (low half first) and stalls the upstream pipeline via ready until the
// access reaches DONE. Non-memory instructions pass straight through.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int SRAM_WAIT = DEF_SRAM_WAIT,
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [31:0]       alu_res_in,
  input  logic [31:0]       val_rm_in,
  input  logic [3:0]        dest_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [31:0]       alu_res_out,
  output logic [3:0]        dest_out,
  output logic [31:0]       mem_res,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

  localparam int CNT_W  = (SRAM_WAIT < 2) ? 1 : $clog2(SRAM_WAIT);
  localparam int WORD_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        lo_q, hi_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        dq_q, dq_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;
  logic [WORD_W-1:0]  word_w;
  logic               last_w;

  // Word index relative to the SRAM window; wraps modulo 2^32, no range check.
  assign word_w = WORD_W'((alu_res_in - 32'(BASE_ADDR)) >> 2);
  assign last_w = (cnt_q == CNT_LAST);

  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en_in;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;
  assign mem_res      = {hi_q, lo_q};
  assign ready        = ~(mem_r_en_in | mem_w_en_in) | (state_q == DONE);

  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

  // Next state, phase counter and the next value of the registered SRAM pins.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = '0;
    dq_d    = '0;
    oe_d    = 1'b0;
    we_n_d  = 1'b1;

    unique case (state_q)
      IDLE: begin
        // A read wins when both enables are raised.
        if (mem_r_en_in)      state_d = RD_LO;
        else if (mem_w_en_in) state_d = WR_LO;
      end
      RD_LO:   if (last_w) state_d = RD_HI;
      RD_HI:   if (last_w) state_d = DONE;
      WR_LO:   if (last_w) state_d = WR_HI;
      WR_HI:   if (last_w) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state entry and only runs inside a phase.
    if ((state_d == state_q) && (state_q != IDLE) && (state_q != DONE))
      cnt_d = cnt_q + 1'b1;

    // Pins are registered, so they are derived from the state being entered.
    unique case (state_d)
      RD_LO: addr_d = {word_w, 1'b0};
      RD_HI: addr_d = {word_w, 1'b1};
      WR_LO: begin
        addr_d = {word_w, 1'b0};
        dq_d   = val_rm_in[15:0];
        oe_d   = 1'b1;
        we_n_d = 1'b0;
      end
      WR_HI: begin
        addr_d = {word_w, 1'b1};
        dq_d   = val_rm_in[31:16];
        oe_d   = 1'b1;
        we_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State, counter and SRAM pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end

  // Capture each read half on the final cycle of its phase; hold until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if ((state_q == RD_LO) && last_w) lo_q <= sram_dq_in;
      if ((state_q == RD_HI) && last_w) hi_q <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram with a behavioural 64K x 16 SRAM whose read data
// trails the address by RD_LAT cycles.
module tb_mem_stage_sram;

  localparam int ADDR_W = 18;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_en, mem_r_en, mem_w_en;
  logic [31:0]       alu_res, val_rm;
  logic [3:0]        dest;
  logic              wb_en_out, mem_r_en_out;
  logic [31:0]       alu_res_out, mem_res;
  logic [3:0]        dest_out;
  logic              ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out, sram_dq_in;
  logic              sram_dq_oe, sram_we_n;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          we_lo;
    int          we_hi;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_stage_sram #(.SRAM_WAIT(3), .BASE_ADDR(1024), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en), .mem_r_en_in(mem_r_en), .mem_w_en_in(mem_w_en),
    .alu_res_in(alu_res), .val_rm_in(val_rm), .dest_in(dest),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .dest_out(dest_out),
    .mem_res(mem_res), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  // SRAM model
  logic [15:0] mem [0:65535];
  logic [15:0] a_d1, a_d2;
  logic [15:0] dq_bus;

  assign dq_bus     = sram_dq_oe ? sram_dq_out : mem[(RD_LAT == 2) ? a_d2 : a_d1];
  assign sram_dq_in = dq_bus;

  always @(posedge clk) begin
    a_d1 <= sram_addr[15:0];
    a_d2 <= a_d1;
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[15:0]] <= dq_bus;
  end

  // Drives one access starting just after a rising edge and waits for ready.
  // Returns the cycle index of DONE (-1 on timeout), the loaded word and
  // per-half write-strobe counts.
  task automatic run_access(input logic r, input logic w, input logic [31:0] addr,
                            input logic [31:0] data, output int cyc,
                            output logic [31:0] res, output int we_lo, output int we_hi);
    logic seen;
    mem_r_en = r; mem_w_en = w; alu_res = addr; val_rm = data; wb_en = r; dest = 4'h3;
    cyc = -1; res = '0; we_lo = 0; we_hi = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (!sram_we_n) begin
          if (sram_addr[0]) we_hi++; else we_lo++;
        end
        if (ready) begin
          cyc = k; res = mem_res; seen = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_en = 0; mem_r_en = 0; mem_w_en = 0;
    alu_res = '0; val_rm = '0; dest = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({ready, sram_we_n, sram_dq_oe} !== 3'b110) begin
      n_err++; $display("FAIL reset_ctl got ready/we_n/oe=%b want 110", {ready, sram_we_n, sram_dq_oe});
    end
    n_vec++;
    if (sram_addr !== '0 || mem_res !== 32'h0) begin
      n_err++; $display("FAIL reset_data got addr=%h mem_res=%h want 0/0", sram_addr, mem_res);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    wb_en = 1'b1; alu_res = 32'h55; dest = 4'hA;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
        n_err++; $display("FAIL pass_ready c%0d got ready=%b we_n=%b want 1/1", k, ready, sram_we_n);
      end
      n_vec++;
      if (alu_res_out !== 32'h55 || wb_en_out !== 1'b1 || dest_out !== 4'hA || mem_r_en_out !== 1'b0) begin
        n_err++; $display("FAIL pass_data c%0d got alu=%h wb=%b dest=%h", k, alu_res_out, wb_en_out, dest_out);
      end
    end
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic test_store();
    int c, lo, hi; logic [31:0] r; exp_t e;
    exp_q.push_back('{res: 32'h0, cyc: 7, we_lo: 3, we_hi: 3});
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, c, r, lo, hi);
    e = exp_q.pop_front();
    n_vec++;
    if (c !== e.cyc) begin n_err++; $display("FAIL str_latency got %0d want %0d", c, e.cyc); end
    n_vec++;
    if (lo !== e.we_lo || hi !== e.we_hi) begin
      n_err++; $display("FAIL str_strobes got lo=%0d hi=%0d want %0d/%0d", lo, hi, e.we_lo, e.we_hi);
    end
    n_vec++;
    if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin
      n_err++; $display("FAIL str_mem got %h_%h want dead_beef", mem[1], mem[0]);
    end
  endtask

  task automatic test_load();
    int c, lo, hi; logic [31:0] r; exp_t e;
    exp_q.push_back('{res: 32'hDEADBEEF, cyc: 7, we_lo: 0, we_hi: 0});
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, c, r, lo, hi);
    e = exp_q.pop_front();
    n_vec++;
    if (c !== e.cyc) begin n_err++; $display("FAIL ldr_latency got %0d want %0d", c, e.cyc); end
    n_vec++;
    if (r !== e.res) begin n_err++; $display("FAIL ldr_data got %h want %h", r, e.res); end
    n_vec++;
    if (lo + hi != 0) begin n_err++; $display("FAIL ldr_no_write got %0d strobes want 0", lo + hi); end
  endtask

  task automatic test_back_to_back();
    int c0, c1, c2, lo, hi; logic [31:0] r; exp_t e;
    exp_q.push_back('{res: 32'h0, cyc: 7, we_lo: 3, we_hi: 3});
    run_access(1'b0, 1'b1, 32'd1028, 32'hF00D0BAD, c0, r, lo, hi);
    e = exp_q.pop_front();
    n_vec++;
    if (c0 !== e.cyc || mem[2] !== 16'h0BAD || mem[3] !== 16'hF00D) begin
      n_err++; $display("FAIL b2b_setup got cyc=%0d mem=%h_%h want 7 f00d_0bad", c0, mem[3], mem[2]);
    end
    exp_q.push_back('{res: 32'hF00D0BAD, cyc: 7, we_lo: 0, we_hi: 0});
    exp_q.push_back('{res: 32'hF00D0BAD, cyc: 7, we_lo: 3, we_hi: 3});
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, c1, r, lo, hi);
    e = exp_q.pop_front();
    n_vec++;
    if (r !== e.res || lo + hi != 0) begin
      n_err++; $display("FAIL b2b_ldr got %h strobes=%0d want %h 0", r, lo + hi, e.res);
    end
    run_access(1'b0, 1'b1, 32'd1032, 32'hCAFEBABE, c2, r, lo, hi);
    e = exp_q.pop_front();
    n_vec++;
    if ((c1 + 1) + (c2 + 1) != 16) begin
      n_err++; $display("FAIL b2b_total got %0d cycles want 16", (c1 + 1) + (c2 + 1));
    end
    n_vec++;
    if (lo !== e.we_lo || hi !== e.we_hi) begin
      n_err++; $display("FAIL b2b_str_strobes got lo=%0d hi=%0d want %0d/%0d", lo, hi, e.we_lo, e.we_hi);
    end
    n_vec++;
    if (mem[4] !== 16'hBABE || mem[5] !== 16'hCAFE || r !== e.res) begin
      n_err++; $display("FAIL b2b_str got mem=%h_%h res=%h want cafe_babe %h", mem[5], mem[4], r, e.res);
    end
  endtask

  task automatic test_reset_mid_write();
    int c, lo, hi; logic [31:0] r; exp_t e;
    mem_w_en = 1'b1; alu_res = 32'd1036; val_rm = 32'h12345678;
    repeat (5) @(negedge clk);
    n_vec++;
    if (sram_we_n !== 1'b0 || sram_addr !== 18'd7 || sram_dq_out !== 16'h1234) begin
      n_err++; $display("FAIL rst_pre got we_n=%b addr=%0d dq=%h want 0 7 1234", sram_we_n, sram_addr, sram_dq_out);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({sram_we_n, sram_dq_oe, ready} !== 3'b100 || sram_addr !== '0 || mem_res !== 32'h0) begin
      n_err++; $display("FAIL rst_mid got we_n/oe/ready=%b addr=%h res=%h want 100 0 0",
                        {sram_we_n, sram_dq_oe, ready}, sram_addr, mem_res);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_w_en = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back('{res: 32'hDEADBEEF, cyc: 7, we_lo: 0, we_hi: 0});
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, c, r, lo, hi);
    e = exp_q.pop_front();
    n_vec++;
    if (c !== e.cyc || r !== e.res) begin
      n_err++; $display("FAIL rst_recover got cyc=%0d res=%h want %0d %h", c, r, e.cyc, e.res);
    end
  endtask

  task automatic test_both_enables();
    int c, lo, hi; logic [31:0] r; exp_t e;
    exp_q.push_back('{res: 32'hDEADBEEF, cyc: 7, we_lo: 0, we_hi: 0});
    run_access(1'b1, 1'b1, 32'd1024, 32'h11112222, c, r, lo, hi);
    e = exp_q.pop_front();
    n_vec++;
    if (lo + hi != 0) begin n_err++; $display("FAIL both_no_write got %0d strobes want 0", lo + hi); end
    n_vec++;
    if (c !== e.cyc || r !== e.res) begin
      n_err++; $display("FAIL both_read got cyc=%0d res=%h want %0d %h", c, r, e.cyc, e.res);
    end
    n_vec++;
    if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin
      n_err++; $display("FAIL both_mem got %h_%h want dead_beef", mem[1], mem[0]);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid_write();
    test_both_enables();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
